// File: rtl/expmul_pipe_pkg.sv
// expmul_pipe_pkg: shared types and default constants for the exp-multiply
// pipeline.
//   score_qt         signed Q4.3 attention score / running max
//   expmul_diff_t    signed Q5.3 difference a - b
//   expmul_l_t       7-bit power-of-two shift amount L
//   expmul_scale_t   {L, h}, where h is the half-step flag
//   expmul_p_qt      unsigned Q1.P_FRAC scale factor at the default P_FRAC
//   expmul_vshift_qt signed lane value at the default lane width
`timescale 1ns/1ps
package expmul_pipe_pkg;

  localparam int EXPMUL_DIM    = 64;
  localparam int EXPMUL_V_W    = 17;
  localparam int EXPMUL_P_FRAC = 15;

  typedef logic signed [7:0]               score_qt;
  typedef logic signed [8:0]               expmul_diff_t;
  typedef logic [6:0]                      expmul_l_t;
  typedef logic [EXPMUL_P_FRAC:0]          expmul_p_qt;
  typedef logic signed [EXPMUL_V_W-1:0]    expmul_vshift_qt;

  typedef struct packed {
    expmul_l_t l;
    logic      h;
  } expmul_scale_t;

endpackage

// File: rtl/expmul_pipe_if.sv
// expmul_pipe_if: valid/ready stream bundle around the exp-multiply pipeline.
//   Upstream side:   vld_in, rdy_out, a_in, b_in, v_in
//   Downstream side: vld_out, rdy_in, v_out, p_out
//   master modport: the environment (producer and consumer).
//   slave modport:  the pipeline itself.
`timescale 1ns/1ps
interface expmul_pipe_if #(
  parameter int DIM    = 64,
  parameter int V_W    = 17,
  parameter int P_FRAC = 15
);
  logic                      vld_in;
  logic                      rdy_out;
  logic [7:0]                a_in;
  logic [7:0]                b_in;
  logic [DIM-1:0][V_W-1:0]   v_in;
  logic                      vld_out;
  logic                      rdy_in;
  logic [DIM-1:0][V_W-1:0]   v_out;
  logic [P_FRAC:0]           p_out;

  modport master (
    output vld_in, a_in, b_in, v_in, rdy_in,
    input  rdy_out, vld_out, v_out, p_out
  );

  modport slave (
    input  vld_in, a_in, b_in, v_in, rdy_in,
    output rdy_out, vld_out, v_out, p_out
  );
endinterface

// File: rtl/expmul_pipe_lane.sv
// expmul_lane: combinational scale of one signed lane by 2^-L, optionally
// followed by the 2^-0.5 ~= 0.6875 half-step correction.
//   v  in   signed W-bit operand
//   l  in   shift amount L
//   h  in   apply half-step correction
//   r  out  signed W-bit result, |r| <= |v|
`timescale 1ns/1ps
module expmul_lane
  import expmul_pipe_pkg::*;
#(
  parameter int W = 17
) (
  input  logic signed [W-1:0] v,
  input  expmul_l_t           l,
  input  logic                h,
  output logic signed [W-1:0] r
);

  logic signed [W-1:0] s;

  always_comb begin
    // Shifting out every bit must give 0 even for negative v, not -1.
    if (int'(l) >= W) s = '0;
    else              s = v >>> l;
    if (h) r = s - (s >>> 2) - (s >>> 4);
    else   r = s;
  end

endmodule

// File: rtl/expmul_pipe.sv
// expmul_pipe: three-stage valid/ready pipeline computing
//   v_out[i] = exp(a - b) * v_in[i]  and  p_out = exp(a - b)
// using exp(x) = 2^(x*log2e), with log2e ~= 1.4375 and 2^-frac rounded
// to either a half step (FRAC_CORR=1) or the nearest integer (FRAC_CORR=0).
// Ports:
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-low reset
//   io       slave side of expmul_pipe_if (input and output streams)
//   clr_err  in   synchronous clear of err_pos
//   err_pos  out  sticky: an accepted beat had a > b (clamped to exp(0))
`timescale 1ns/1ps
module expmul_pipe
  import expmul_pipe_pkg::*;
#(
  parameter int DIM       = EXPMUL_DIM,
  parameter int V_W       = EXPMUL_V_W,
  parameter int P_FRAC    = EXPMUL_P_FRAC,
  parameter int FRAC_CORR = 1
) (
  input  logic             clk,
  input  logic             rst,
  expmul_pipe_if.slave     io,
  input  logic             clr_err,
  output logic             err_pos
);

  // p is pushed through a signed lane one bit wider than Q1.P_FRAC so
  // the unsigned 1.0 operand stays non-negative and shifts logically.
  localparam int P_W = P_FRAC + 2;
  localparam logic signed [P_W-1:0] P_ONE = P_W'(1) << P_FRAC;

  // X = -d (LSB 1/8), Y = X*1.4375 in the same units; L is the integer
  // part of Y/8, h the half-step bit (or round-to-nearest when disabled).
  function automatic expmul_scale_t log2e_scale(input expmul_diff_t d);
    logic [9:0]    x;
    logic [9:0]    y;
    expmul_scale_t r;
    x = 10'(-d);
    y = x + (x >> 1) - (x >> 4);
    if (FRAC_CORR != 0) begin
      r.l = expmul_l_t'(y >> 3);
      r.h = 1'(y >> 2);
    end else begin
      y   = y + 10'd4;
      r.l = expmul_l_t'(y >> 3);
      r.h = 1'b0;
    end
    return r;
  endfunction

  logic vld_p0_q, vld_p0_d;
  logic vld_p1_q, vld_p1_d;
  logic vld_p2_q, vld_p2_d;
  logic adv_p0, adv_p1, adv_p2;
  logic accept, rdy_out;

  score_qt                 a_p0_q, a_p0_d;
  score_qt                 b_p0_q, b_p0_d;
  logic [DIM-1:0][V_W-1:0] v_p0_q, v_p0_d;
  expmul_diff_t            d_raw, d_clamp;
  logic                    pos_hit;

  expmul_scale_t           scale_p1_q, scale_p1_d;
  logic [DIM-1:0][V_W-1:0] v_p1_q, v_p1_d;

  logic [DIM-1:0][V_W-1:0] lane_res;
  logic signed [P_W-1:0]   p_res;
  logic [DIM-1:0][V_W-1:0] v_p2_q, v_p2_d;
  logic [P_FRAC:0]         p_p2_q, p_p2_d;

  logic err_pos_q, err_pos_d;

  // Handshake: a stage moves when the next one is empty or moving.
  always_comb begin
    adv_p2   = vld_p2_q & io.rdy_in;
    adv_p1   = vld_p1_q & (~vld_p2_q | adv_p2);
    adv_p0   = vld_p0_q & (~vld_p1_q | adv_p1);
    rdy_out  = ~vld_p0_q | adv_p0;
    accept   = io.vld_in & rdy_out;
    vld_p0_d = accept | (vld_p0_q & ~adv_p0);
    vld_p1_d = adv_p0 | (vld_p1_q & ~adv_p1);
    vld_p2_d = adv_p1 | (vld_p2_q & ~adv_p2);
  end

  // S1 -> S2: difference, clamp of positive d, log2e scaling.
  always_comb begin
    d_raw   = expmul_diff_t'(a_p0_q) - expmul_diff_t'(b_p0_q);
    pos_hit = (d_raw > 0);
    d_clamp = pos_hit ? '0 : d_raw;
  end

  // S2 -> S3: per-lane scale and the p path.
  for (genvar i = 0; i < DIM; i++) begin : g_lane
    expmul_lane #(.W(V_W)) u_lane (
      .v (v_p1_q[i]),
      .l (scale_p1_q.l),
      .h (scale_p1_q.h),
      .r (lane_res[i])
    );
  end

  expmul_lane #(.W(P_W)) u_p_lane (
    .v (P_ONE),
    .l (scale_p1_q.l),
    .h (scale_p1_q.h),
    .r (p_res)
  );

  always_comb begin
    a_p0_d     = a_p0_q;
    b_p0_d     = b_p0_q;
    v_p0_d     = v_p0_q;
    scale_p1_d = scale_p1_q;
    v_p1_d     = v_p1_q;
    v_p2_d     = v_p2_q;
    p_p2_d     = p_p2_q;
    if (accept) begin
      a_p0_d = score_qt'(io.a_in);
      b_p0_d = score_qt'(io.b_in);
      v_p0_d = io.v_in;
    end
    if (adv_p0) begin
      scale_p1_d = log2e_scale(d_clamp);
      v_p1_d     = v_p0_q;
    end
    if (adv_p1) begin
      v_p2_d = lane_res;
      p_p2_d = (P_FRAC+1)'(p_res);
    end
    // A new violation leaving S1 wins over a coincident clear.
    err_pos_d = (adv_p0 & pos_hit) | (err_pos_q & ~clr_err);
  end

  // Stage S1 and S2 data: no reset, qualified by the valids.
  always_ff @(posedge clk) begin
    a_p0_q     <= a_p0_d;
    b_p0_q     <= b_p0_d;
    v_p0_q     <= v_p0_d;
    scale_p1_q <= scale_p1_d;
    v_p1_q     <= v_p1_d;
  end

  // Control, output stage and sticky flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p0_q  <= 1'b0;
      vld_p1_q  <= 1'b0;
      vld_p2_q  <= 1'b0;
      v_p2_q    <= '0;
      p_p2_q    <= '0;
      err_pos_q <= 1'b0;
    end else begin
      vld_p0_q  <= vld_p0_d;
      vld_p1_q  <= vld_p1_d;
      vld_p2_q  <= vld_p2_d;
      v_p2_q    <= v_p2_d;
      p_p2_q    <= p_p2_d;
      err_pos_q <= err_pos_d;
    end
  end

  assign io.rdy_out  = rdy_out;
  assign io.vld_out  = vld_p2_q;
  assign io.v_out    = v_p2_q;
  assign io.p_out    = p_p2_q;
  assign err_pos     = err_pos_q;

endmodule

// File: tb/tb_expmul_pipe.sv
`timescale 1ns/1ps
module tb_expmul_pipe;

  localparam int DIM    = 4;
  localparam int V_W    = 17;
  localparam int P_FRAC = 15;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic                    vld_in  = 1'b0;
  logic                    rdy_in  = 1'b0;
  logic                    clr_err = 1'b0;
  logic [7:0]              a_in    = '0;
  logic [7:0]              b_in    = '0;
  logic [DIM-1:0][V_W-1:0] v_in    = '0;
  logic                    err_c, err_r;

  expmul_pipe_if #(.DIM(DIM), .V_W(V_W), .P_FRAC(P_FRAC)) ic ();
  expmul_pipe_if #(.DIM(DIM), .V_W(V_W), .P_FRAC(P_FRAC)) ir ();

  assign ic.vld_in = vld_in;  assign ir.vld_in = vld_in;
  assign ic.rdy_in = rdy_in;  assign ir.rdy_in = rdy_in;
  assign ic.a_in   = a_in;    assign ir.a_in   = a_in;
  assign ic.b_in   = b_in;    assign ir.b_in   = b_in;
  assign ic.v_in   = v_in;    assign ir.v_in   = v_in;

  expmul_pipe #(.DIM(DIM), .V_W(V_W), .P_FRAC(P_FRAC), .FRAC_CORR(1)) dut_c (
    .clk(clk), .rst(rst), .io(ic), .clr_err(clr_err), .err_pos(err_c));
  expmul_pipe #(.DIM(DIM), .V_W(V_W), .P_FRAC(P_FRAC), .FRAC_CORR(0)) dut_r (
    .clk(clk), .rst(rst), .io(ir), .clr_err(clr_err), .err_pos(err_r));

  typedef struct packed {
    logic [DIM-1:0][V_W-1:0] vc;
    logic [DIM-1:0][V_W-1:0] vr;
    logic [P_FRAC:0]         pc;
    logic [P_FRAC:0]         pr;
    logic [31:0]             e;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   edges    = 0;
  bit   last_acc;

  always @(posedge clk) edges <= edges + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    assert (got === want)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, want);
    end
  endtask

  function automatic logic [63:0] vx(input longint x);
    logic [V_W-1:0] t;
    t = V_W'(x);
    return 64'(t);
  endfunction

  // ---- reference model: exp(a-b) from the arithmetic rules ----
  function automatic longint fdiv(input longint n, input longint m);
    longint r;
    r = n / m;
    if ((n % m != 0) && (n < 0)) r = r - 1;
    return r;
  endfunction

  function automatic void scale_of(input int a, input int b, input bit corr,
                                   output int l, output bit h);
    int d, x, y;
    d = a - b;
    if (d > 0) d = 0;
    x = -d;
    y = x + x / 2 - x / 16;
    if (corr) begin l = y / 8;       h = ((y / 4) % 2) == 1; end
    else      begin l = (y + 4) / 8; h = 1'b0;               end
  endfunction

  function automatic longint apply(input longint v, input int l, input bit h);
    longint s;
    if (l >= V_W) return 0;
    s = fdiv(v, longint'(1) << l);
    if (h) s = s - fdiv(s, 4) - fdiv(s, 16);
    return s;
  endfunction

  function automatic longint pmodel(input int l, input bit h);
    longint s;
    if (l > P_FRAC) return 0;
    s = (longint'(1) << P_FRAC) / (longint'(1) << l);
    if (h) s = s - s / 4 - s / 16;
    return s;
  endfunction

  task automatic push_beat();
    exp_t e;
    int   l;
    bit   h;
    scale_of(int'($signed(a_in)), int'($signed(b_in)), 1'b1, l, h);
    for (int i = 0; i < DIM; i++) e.vc[i] = V_W'(apply(longint'($signed(v_in[i])), l, h));
    e.pc = (P_FRAC+1)'(pmodel(l, h));
    scale_of(int'($signed(a_in)), int'($signed(b_in)), 1'b0, l, h);
    for (int i = 0; i < DIM; i++) e.vr[i] = V_W'(apply(longint'($signed(v_in[i])), l, h));
    e.pr = (P_FRAC+1)'(pmodel(l, h));
    e.e  = 32'(edges + 1);
    q.push_back(e);
  endtask

  // Called at a falling edge with inputs set; advances to the next one.
  task automatic cycle();
    bit ev, er;
    #1;
    ev = (q.size() > 0) && (edges >= int'(q[0].e) + 2);
    er = (q.size() < 3) || rdy_in;
    chk("vld_out_c", 64'(ic.vld_out), 64'(ev));
    chk("vld_out_r", 64'(ir.vld_out), 64'(ev));
    chk("rdy_out_c", 64'(ic.rdy_out), 64'(er));
    chk("rdy_out_r", 64'(ir.rdy_out), 64'(er));
    if (ev) begin
      for (int i = 0; i < DIM; i++) begin
        chk($sformatf("v_out_c[%0d]", i), 64'(ic.v_out[i]), 64'(q[0].vc[i]));
        chk($sformatf("v_out_r[%0d]", i), 64'(ir.v_out[i]), 64'(q[0].vr[i]));
      end
      chk("p_out_c", 64'(ic.p_out), 64'(q[0].pc));
      chk("p_out_r", 64'(ir.p_out), 64'(q[0].pr));
    end
    if (ev && rdy_in) void'(q.pop_front());
    last_acc = vld_in && er;
    if (last_acc) push_beat();
    @(negedge clk);
  endtask

  task automatic send1(input logic [7:0] a, input logic [7:0] b,
                       input logic [V_W-1:0] v0, input logic [V_W-1:0] v1);
    vld_in = 1'b1; a_in = a; b_in = b;
    v_in[0] = v0; v_in[1] = v1;
    for (int i = 2; i < DIM; i++) v_in[i] = V_W'($urandom);
    cycle();
    vld_in = 1'b0;
    cycle();
    cycle();
  endtask

  initial begin
    int sent;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_vld_out", 64'(ic.vld_out), 64'd0);
    chk("rst_v_out", 64'(ic.v_out[0]), 64'd0);
    chk("rst_p_out", 64'(ic.p_out), 64'd0);
    chk("rst_err", 64'(err_c), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    rdy_in = 1'b1;

    // a = b = 0: unity scale
    send1(8'h00, 8'h00, 17'h00100, 17'h00000);
    chk("unity_vld", 64'(ic.vld_out), 64'd1);
    chk("unity_v0", 64'(ic.v_out[0]), 64'h100);
    chk("unity_p", 64'(ic.p_out), 64'h8000);
    chk("unity_err", 64'(err_c), 64'd0);
    cycle();

    // d = -1.0: half-step vs round-to-nearest
    send1(8'h00, 8'h08, 17'd256, vx(-256));
    chk("corr_v0", 64'(ic.v_out[0]), vx(88));
    chk("corr_v1", 64'(ic.v_out[1]), vx(-88));
    chk("corr_p", 64'(ic.p_out), 64'd11264);
    chk("rnd_v0", 64'(ir.v_out[0]), vx(64));
    chk("rnd_v1", 64'(ir.v_out[1]), vx(-64));
    chk("rnd_p", 64'(ir.p_out), 64'd8192);
    cycle();

    // very negative d: every lane to zero, including negative ones
    send1(8'h80, 8'h7F, vx(-256), 17'h0FFFF);
    for (int i = 0; i < DIM; i++) begin
      chk($sformatf("big_c[%0d]", i), 64'(ic.v_out[i]), 64'd0);
      chk($sformatf("big_r[%0d]", i), 64'(ir.v_out[i]), 64'd0);
    end
    chk("big_p", 64'(ic.p_out), 64'd0);
    chk("big_err", 64'(err_c), 64'd0);
    cycle();

    // a > b: clamp, sticky flag, clear, set-wins-over-clear
    send1(8'h10, 8'h00, 17'd256, vx(-256));
    chk("pos_v0", 64'(ic.v_out[0]), 64'd256);
    chk("pos_v1", 64'(ic.v_out[1]), vx(-256));
    chk("pos_p", 64'(ic.p_out), 64'h8000);
    chk("pos_err_c", 64'(err_c), 64'd1);
    chk("pos_err_r", 64'(err_r), 64'd1);
    cycle(); cycle();
    chk("pos_err_held", 64'(err_c), 64'd1);
    clr_err = 1'b1;
    cycle();
    clr_err = 1'b0;
    chk("clr_err", 64'(err_c), 64'd0);
    vld_in = 1'b1; a_in = 8'h10; b_in = 8'h00;
    cycle();
    chk("pre_coinc_err", 64'(err_c), 64'd0);
    vld_in = 1'b0; clr_err = 1'b1;
    cycle();
    clr_err = 1'b0;
    chk("coinc_err_c", 64'(err_c), 64'd1);
    chk("coinc_err_r", 64'(err_r), 64'd1);
    cycle(); cycle();
    clr_err = 1'b1;
    cycle();
    clr_err = 1'b0;

    // 6 beats with downstream stalled for cycles 2..6
    sent = 0;
    a_in = 8'($urandom_range(0, 255)); b_in = 8'h7F;
    for (int i = 0; i < DIM; i++) v_in[i] = V_W'(100 * i + 7);
    for (int c = 0; c < 40 && sent < 6; c++) begin
      rdy_in = !(c >= 2 && c <= 6);
      vld_in = 1'b1;
      cycle();
      if (last_acc) begin
        sent++;
        a_in = 8'($urandom_range(0, 255));
        for (int i = 0; i < DIM; i++) v_in[i] = V_W'(1000 * sent + 100 * i + 7);
      end
    end
    chk("stream_sent", 64'(sent), 64'd6);
    vld_in = 1'b0; rdy_in = 1'b1;
    for (int c = 0; c < 20 && q.size() > 0; c++) cycle();
    chk("stream_drain", 64'(q.size()), 64'd0);

    // randomized traffic with random back-pressure
    for (int c = 0; c < 400; c++) begin
      vld_in = ($urandom_range(0, 3) != 0);
      rdy_in = ($urandom_range(0, 3) != 0);
      a_in   = 8'($urandom);
      b_in   = 8'($urandom);
      for (int i = 0; i < DIM; i++) v_in[i] = V_W'($urandom);
      cycle();
    end

    // fill the pipe, then reset mid-stream
    rdy_in = 1'b0; vld_in = 1'b1; a_in = 8'h10; b_in = 8'h00;
    repeat (4) cycle();
    rst = 1'b0;
    #1;
    chk("mid_rst_vld_c", 64'(ic.vld_out), 64'd0);
    chk("mid_rst_vld_r", 64'(ir.vld_out), 64'd0);
    chk("mid_rst_v0", 64'(ic.v_out[0]), 64'd0);
    chk("mid_rst_p", 64'(ic.p_out), 64'd0);
    chk("mid_rst_err", 64'(err_c), 64'd0);
    q.delete();
    @(negedge clk);
    rst = 1'b1; vld_in = 1'b0; rdy_in = 1'b1;
    repeat (6) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
